// File: rtl/gate_pkg.sv
// Shared op/state encodings and the lane-wise evaluator for gate_array.
// Optional reduction flags are enabled with GATE_ARRAY_REDUCE_EN.
package gate_pkg;

  // Widest operand gate_eval handles; narrower callers zero-extend and slice.
  localparam int unsigned GateMaxW = 256;

  typedef enum logic [2:0] {
    OpNor   = 3'b000,
    OpNand  = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpXnor  = 3'b101,
    OpNotA  = 3'b110,
    OpPassA = 3'b111
  } gate_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } gate_state_e;

  function automatic logic [GateMaxW-1:0] gate_eval(input gate_op_e            op,
                                                    input logic [GateMaxW-1:0] a,
                                                    input logic [GateMaxW-1:0] b);
    logic [GateMaxW-1:0] y;
    case (op)
      OpNor:   y = ~(a | b);
      OpNand:  y = ~(a & b);
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpXnor:  y = ~(a ^ b);
      OpNotA:  y = ~a;
      OpPassA: y = a;
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_skid_buf.sv
// Two-entry (main + skid) valid/ready buffer with registered in_ready and outputs.
// Payload width is set by the parent (wider when GATE_ARRAY_REDUCE_EN is defined).
module gate_skid_buf
  import gate_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  gate_state_e      state_q;
  logic [Width-1:0] main_q;
  logic [Width-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state_q   <= StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            // Head leaves while the new result takes its place.
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state_q  <= StFull;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state_q   <= StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state_q  <= StOne;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= StEmpty;
        end
      endcase
    end
  end

endmodule

// File: rtl/gate_array.sv
// Registered W-bit bitwise logic unit: eight selectable ops feeding a skid buffer.
// Define GATE_ARRAY_REDUCE_EN to add per-entry out_any/out_all reduction flags.
module gate_array
  import gate_pkg::*;
#(
  parameter int unsigned W = 8  // 1 .. GateMaxW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y
`ifdef GATE_ARRAY_REDUCE_EN
  ,
  output logic         out_any,
  output logic         out_all
`endif
);

`ifdef GATE_ARRAY_REDUCE_EN
  localparam int unsigned RedW = 2;
`else
  localparam int unsigned RedW = 0;
`endif
  localparam int unsigned PayW = W + RedW;

  logic [GateMaxW-1:0] y_full;
  logic [W-1:0]        y;
  logic [PayW-1:0]     pay_in;
  logic [PayW-1:0]     pay_out;
  logic                unused_y_full;

  assign y_full        = gate_eval(gate_op_e'(in_op), GateMaxW'(in_a), GateMaxW'(in_b));
  assign y             = y_full[W-1:0];
  assign unused_y_full = ^y_full;

`ifdef GATE_ARRAY_REDUCE_EN
  // Flags are frozen with the entry so they always match the presented out_y.
  assign pay_in  = {|y, &y, y};
  assign out_any = pay_out[W+1];
  assign out_all = pay_out[W];
`else
  assign pay_in  = y;
`endif
  assign out_y = pay_out[W-1:0];

  gate_skid_buf #(
    .Width(PayW)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

endmodule
